tetris_move_sched: RTL and testbench

- Sequences every change to the active piece in the falling-piece datapath.
- Collects move requests from gravity ticks and player buttons, arbitrates them, and issues one move at a time to the collision-check datapath over a req/ready/done handshake.
- On the result, either commits the move or runs the lock-delay logic.
- Sits between the game FSM and the movedown/collision logic; its lock pulse is the FSM's FALLING->LANDED trigger.

---
 rtl/tetris_pkg.sv | 50 +++++
 rtl/tetris_move_sched_if.sv | 30 +++
 rtl/tetris_lock_timer.sv | 33 +++
 rtl/tetris_move_sched.sv | 170 +++++++++++++++++
 tb/tb_tetris_move_sched.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece move scheduler.
//   move_op_t     : operation sent to the collision-check datapath
//   sched_state_t : scheduler FSM state, also exported for debug
//   SRC_*         : bit positions of the per-source pending flags; a higher
//                   index means a higher arbitration priority
//   pick_highest  : one-hot grant of the highest-priority pending flag
//   op_for        : maps a one-hot grant to the move it requests
package tetris_pkg;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    ROT   = 2'd3
  } move_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } sched_state_t;

  localparam int SRC_RIGHT = 0;
  localparam int SRC_LEFT  = 1;
  localparam int SRC_ROT   = 2;
  localparam int SRC_GRAV  = 3;
  localparam int SRC_DROP  = 4;
  localparam int NUM_SRC   = 5;

  // Ascending scan: the last set bit seen (the highest index) wins.
  function automatic logic [NUM_SRC-1:0] pick_highest(input logic [NUM_SRC-1:0] pend);
    pick_highest = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend[i]) begin
        pick_highest    = '0;
        pick_highest[i] = 1'b1;
      end
    end
  endfunction

  // Drop and gravity both move the piece down.
  function automatic move_op_t op_for(input logic [NUM_SRC-1:0] grant);
    if (grant[SRC_ROT])        op_for = ROT;
    else if (grant[SRC_LEFT])  op_for = LEFT;
    else if (grant[SRC_RIGHT]) op_for = RIGHT;
    else                       op_for = DOWN;
  endfunction

endpackage

// File: rtl/tetris_move_sched_if.sv
// Request/result channel between the move scheduler and the collision-check
// datapath.
//   chk_req     : scheduler -> datapath, request pending
//   chk_op      : scheduler -> datapath, move to check
//   chk_ready   : datapath -> scheduler, request accepted this cycle
//   chk_done    : datapath -> scheduler, one-cycle result strobe
//   chk_collide : datapath -> scheduler, move blocked (valid with chk_done)
// Handshake: a request is transferred on the rising edge where chk_req and
// chk_ready are both high; chk_op is held stable while chk_req is high. The
// result is the single later cycle in which chk_done is high; chk_done at
// any other time carries no meaning and is ignored.
interface tetris_move_sched_if;
  import tetris_pkg::*;

  logic     chk_req;
  move_op_t chk_op;
  logic     chk_ready;
  logic     chk_done;
  logic     chk_collide;

  modport master (
    output chk_req, chk_op,
    input  chk_ready, chk_done, chk_collide
  );

  modport slave (
    input  chk_req, chk_op,
    output chk_ready, chk_done, chk_collide
  );
endinterface

// File: rtl/tetris_lock_timer.sv
// Lock-delay counter: counts consecutive blocked gravity moves.
//   clk, reset : clock, synchronous active-high reset
//   inc        : a gravity move was blocked this cycle
//   clr        : a move succeeded, or the piece is gone; restart the count
//   expire     : combinational, high with the inc that reaches LOCK_DELAY
//   count      : current count, for debug visibility
// The count returns to zero on expiry and never wraps.
module tetris_lock_timer #(
  parameter int LOCK_DELAY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inc,
  input  logic                              clr,
  output logic                              expire,
  output logic [$clog2(LOCK_DELAY+1)-1:0]   count
);
  localparam int CW = $clog2(LOCK_DELAY+1);
  localparam logic [CW-1:0] LAST = CW'(LOCK_DELAY-1);
  localparam logic [CW-1:0] MAX  = CW'(LOCK_DELAY);

  assign expire = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (expire) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/tetris_move_sched.sv
// Move scheduler for the active piece. Latches gravity ticks and player
// buttons as pending flags, grants them one at a time by fixed priority
// (drop > gravity > rotate > left > right), runs each move through the
// collision-check datapath and then commits it or advances the lock delay.
//   clk, reset      : clock, synchronous active-high reset
//   piece_active    : game FSM is in FALLING; low flushes everything
//   tick            : gravity pulse
//   btn_left/right/rotate/drop : one-cycle button pulses
//   chk             : request/result channel to the collision datapath
//   commit          : one-cycle pulse, apply the checked move
//   lock            : one-cycle pulse, piece has landed
//   busy            : FSM not in IDLE
//   dbg_state       : current FSM state
//   dbg_lock_cnt    : current lock-delay count
module tetris_move_sched
  import tetris_pkg::*;
#(
  parameter int LOCK_DELAY = 2,
  parameter int ROWS       = 22
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              piece_active,
  input  logic                              tick,
  input  logic                              btn_left,
  input  logic                              btn_right,
  input  logic                              btn_rotate,
  input  logic                              btn_drop,
  tetris_move_sched_if.master               chk,
  output logic                              commit,
  output logic                              lock,
  output logic                              busy,
  output sched_state_t                      dbg_state,
  output logic [$clog2(LOCK_DELAY+1)-1:0]   dbg_lock_cnt
);
  localparam int DW = $clog2(ROWS+1);
  localparam logic [DW-1:0] DROP_LAST = DW'(ROWS-1);

  sched_state_t       state;
  move_op_t           op;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pulse;
  logic [NUM_SRC-1:0] grant;
  logic               drop_active;
  logic               force_lock;
  logic [DW-1:0]      drop_cnt;
  logic               res_valid;
  logic               res_down;
  logic               timer_inc;
  logic               timer_clr;
  logic               timer_expire;

  assign dbg_state  = state;
  assign chk.chk_op = op;

  // Opposite horizontal buttons together cancel each other.
  always_comb begin
    pulse            = '0;
    pulse[SRC_DROP]  = btn_drop;
    pulse[SRC_GRAV]  = tick;
    pulse[SRC_ROT]   = btn_rotate;
    pulse[SRC_LEFT]  = btn_left & ~btn_right;
    pulse[SRC_RIGHT] = btn_right & ~btn_left;
  end

  // No grants outside IDLE; a running hard drop keeps other flags parked.
  assign grant = ((state == IDLE) && !drop_active) ? pick_highest(pend) : '0;

  assign res_valid = (state == WAIT) && chk.chk_done;
  assign res_down  = (op == DOWN);
  assign timer_inc = res_valid && chk.chk_collide && res_down && !drop_active;
  // Any successful move restarts the lock delay, as does a drop landing.
  assign timer_clr = !piece_active ||
                     (res_valid && (!chk.chk_collide || (res_down && drop_active)));

  tetris_lock_timer #(
    .LOCK_DELAY (LOCK_DELAY)
  ) u_lock_timer (
    .clk    (clk),
    .reset  (reset),
    .inc    (timer_inc),
    .clr    (timer_clr),
    .expire (timer_expire),
    .count  (dbg_lock_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset || !piece_active) begin
      state       <= IDLE;
      op          <= DOWN;
      pend        <= '0;
      chk.chk_req <= 1'b0;
      commit      <= 1'b0;
      lock        <= 1'b0;
      busy        <= 1'b0;
      drop_active <= 1'b0;
      force_lock  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      commit <= 1'b0;
      lock   <= 1'b0;
      // A landed piece discards everything queued for it, including pulses
      // arriving in the lock cycle itself.
      pend <= lock ? '0 : ((pend & ~grant) | pulse);

      case (state)
        IDLE: begin
          if (grant != '0) begin
            state       <= REQ;
            chk.chk_req <= 1'b1;
            busy        <= 1'b1;
            op          <= op_for(grant);
            if (grant[SRC_DROP]) begin
              drop_active <= 1'b1;
              drop_cnt    <= '0;
            end
          end
        end

        REQ: begin
          if (chk.chk_ready) begin
            chk.chk_req <= 1'b0;
            state       <= WAIT;
          end
        end

        WAIT: begin
          // The pulses are decided here so they are registered for RESULT.
          if (chk.chk_done) begin
            state <= RESULT;
            if (!chk.chk_collide) begin
              commit <= 1'b1;
              if (res_down && drop_active) begin
                drop_cnt <= drop_cnt + 1'b1;
                if (drop_cnt == DROP_LAST) force_lock <= 1'b1;
              end
            end else if (res_down) begin
              lock <= drop_active | timer_expire;
            end
          end
        end

        RESULT: begin
          if (force_lock) begin
            // Drop hit the row cap: spend one extra RESULT cycle on the lock
            // so it never coincides with the final commit.
            force_lock <= 1'b0;
            lock       <= 1'b1;
          end else if (lock) begin
            drop_active <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end else if (drop_active && commit) begin
            state       <= REQ;
            chk.chk_req <= 1'b1;
            op          <= DOWN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tetris_move_sched.sv
module tb_tetris_move_sched;
  import tetris_pkg::*;

  localparam int LOCK_DELAY = 2;
  localparam int ROWS       = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic piece_active, tick, btn_left, btn_right, btn_rotate, btn_drop;
  logic commit, lock, busy;
  sched_state_t dbg_state;
  logic [$clog2(LOCK_DELAY+1)-1:0] dbg_lock_cnt;

  always #5 clk = ~clk;

  tetris_move_sched_if chk();

  tetris_move_sched #(
    .LOCK_DELAY (LOCK_DELAY),
    .ROWS       (ROWS)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .piece_active (piece_active),
    .tick         (tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_rotate   (btn_rotate),
    .btn_drop     (btn_drop),
    .chk          (chk.master),
    .commit       (commit),
    .lock         (lock),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_lock_cnt (dbg_lock_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- datapath responder ----------------
  int   fixed_delay = 0;   // -1: random delay 0..3 after acceptance
  bit   ready_rand  = 0;
  bit   col_rand    = 0;
  bit   spurious    = 0;
  logic col_plan[$];
  bit   acc_last    = 0;
  bit   out_pend    = 0;
  int   out_cnt     = 0;

  initial begin
    chk.chk_ready   = 1'b0;
    chk.chk_done    = 1'b0;
    chk.chk_collide = 1'b0;
    forever begin
      @(posedge clk); #1;
      chk.chk_done    = 1'b0;
      chk.chk_collide = 1'b0;
      if (acc_last) begin
        out_pend = 1;
        out_cnt  = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
      end
      if (out_pend) begin
        if (out_cnt == 0) begin
          chk.chk_done = 1'b1;
          if (col_plan.size() > 0) chk.chk_collide = col_plan.pop_front();
          else chk.chk_collide = col_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
          out_pend = 0;
        end else begin
          out_cnt--;
        end
      end else if (spurious && $urandom_range(0, 19) == 0) begin
        chk.chk_done    = 1'b1;
        chk.chk_collide = $urandom_range(0, 1) == 1;
      end
      chk.chk_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc_last = chk.chk_req && chk.chk_ready;
    end
  end

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 requesting, 2 awaiting result, 3 reporting result.
  int       m_ph = 0, m_op = 0, m_lc = 0, m_dcnt = 0;
  bit       m_req = 0, m_commit = 0, m_lock = 0, m_busy = 0, m_drop = 0, m_force = 0;
  bit [4:0] m_pend = 0;   // [4] drop, [3] gravity, [2] rotate, [1] left, [0] right

  task automatic model_step();
    bit [4:0] pulses, gmask;
    bit was_lock, was_commit;
    if (rst || !piece_active) begin
      m_ph = 0; m_pend = 0; m_lc = 0; m_req = 0; m_commit = 0; m_lock = 0;
      m_drop = 0; m_force = 0; m_dcnt = 0; m_busy = 0;
      return;
    end
    pulses = {btn_drop, tick, btn_rotate, btn_left && !btn_right, btn_right && !btn_left};
    was_lock = m_lock; was_commit = m_commit;
    m_commit = 0; m_lock = 0; gmask = 0;
    case (m_ph)
      0: begin
        for (int i = 4; i >= 0; i--) if (m_pend[i] && gmask == 0) gmask[i] = 1;
        if (gmask != 0) begin
          m_ph = 1; m_req = 1;
          m_op = (gmask[4] || gmask[3]) ? 0 : gmask[2] ? 3 : gmask[1] ? 1 : 2;
          if (gmask[4]) begin m_drop = 1; m_dcnt = 0; end
        end
      end
      1: if (chk.chk_ready) begin m_req = 0; m_ph = 2; end
      2: if (chk.chk_done) begin
        m_ph = 3;
        if (!chk.chk_collide) begin
          m_commit = 1; m_lc = 0;
          if (m_op == 0 && m_drop) begin
            m_dcnt++;
            if (m_dcnt == ROWS) m_force = 1;
          end
        end else if (m_op == 0) begin
          if (m_drop) begin m_lock = 1; m_lc = 0; end
          else begin
            m_lc++;
            if (m_lc == LOCK_DELAY) begin m_lock = 1; m_lc = 0; end
          end
        end
      end
      default: begin
        if (m_force) begin m_force = 0; m_lock = 1; end
        else if (was_lock) begin m_drop = 0; m_ph = 0; end
        else if (m_drop && was_commit) begin m_ph = 1; m_req = 1; m_op = 0; end
        else m_ph = 0;
      end
    endcase
    m_pend = was_lock ? 5'd0 : ((m_pend & ~gmask) | pulses);
    m_busy = (m_ph != 0);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step();
  end

  // ---------------- scoreboard / compare ----------------
  logic [1:0] exp_q[$];
  logic [1:0] op_q[$];
  int         commit_q[$];
  int         lock_q[$];
  bit         req_prev  = 0;
  bit         busy_seen = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("chk_req", chk.chk_req, m_req);
      if (m_req) check("chk_op", chk.chk_op, m_op);
      check("commit", commit, m_commit);
      check("lock", lock, m_lock);
      check("busy", busy, m_busy);
      check("state", dbg_state, m_ph);
      check("lock_cnt", dbg_lock_cnt, m_lc);
      check("pulse_excl", commit && lock, 0);
      if (chk.chk_req && !req_prev) op_q.push_back(chk.chk_op);
      if (commit) commit_q.push_back(cyc);
      if (lock) lock_q.push_back(cyc);
      if (busy) busy_seen = 1;
      req_prev = chk.chk_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    op_q.delete(); commit_q.delete(); lock_q.delete(); exp_q.delete();
    busy_seen = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input bit t, input bit bl, input bit br, input bit brot,
                             input bit bd, output int at_cyc);
    @(posedge clk); #1;
    tick = t; btn_left = bl; btn_right = br; btn_rotate = brot; btn_drop = bd;
    at_cyc = cyc;
    @(posedge clk); #1;
    tick = 0; btn_left = 0; btn_right = 0; btn_rotate = 0; btn_drop = 0;
  endtask

  task automatic check_ops(input string name);
    check({name, "_nops"}, op_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < op_q.size(); i++)
      check({name, "_op"}, op_q[i], exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1, n;
    bit found;
    rst = 1; piece_active = 0;
    tick = 0; btn_left = 0; btn_right = 0; btn_rotate = 0; btn_drop = 0;
    idle_cycles(3);
    check("rst_req", chk.chk_req, 0);
    check("rst_commit", commit, 0);
    check("rst_lock", lock, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_lock_cnt", dbg_lock_cnt, 0);
    rst = 0; piece_active = 1;
    idle_cycles(2);

    // Single gravity move, no collision.
    clear_logs();
    drive_pulse(1, 0, 0, 0, 0, c0);
    idle_cycles(10);
    check("t1_commits", commit_q.size(), 1);
    if (commit_q.size() > 0) check("t1_latency", commit_q[0] - c0, 4);
    check("t1_locks", lock_q.size(), 0);
    exp_q.push_back(2'd0);
    check_ops("t1");

    // Rotate outranks left.
    clear_logs();
    drive_pulse(0, 1, 0, 1, 0, c0);
    idle_cycles(14);
    check("t2_commits", commit_q.size(), 2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    check_ops("t2");

    // Left and right together cancel.
    clear_logs();
    drive_pulse(0, 1, 1, 0, 0, c0);
    idle_cycles(10);
    check("t3_busy_seen", busy_seen, 0);
    check("t3_nops", op_q.size(), 0);

    // Lock delay of two blocked gravity moves.
    clear_logs();
    col_plan.push_back(1'b1);
    drive_pulse(1, 0, 0, 0, 0, c0);
    idle_cycles(10);
    check("t4_lock_first", lock_q.size(), 0);
    check("t4_cnt_first", dbg_lock_cnt, 1);
    col_plan.push_back(1'b1);
    drive_pulse(1, 0, 0, 0, 0, c0);
    idle_cycles(10);
    check("t4_lock_second", lock_q.size(), 1);
    if (lock_q.size() > 0) check("t4_lock_at", lock_q[0] - c0, 4);
    check("t4_cnt_after", dbg_lock_cnt, 0);
    check("t4_commits", commit_q.size(), 0);

    // Hard drop landing on the fifth DOWN; left pressed mid-drop is flushed.
    clear_logs();
    for (int i = 0; i < 4; i++) col_plan.push_back(1'b0);
    col_plan.push_back(1'b1);
    drive_pulse(0, 0, 0, 0, 1, c0);
    idle_cycles(3);
    drive_pulse(0, 1, 0, 0, 0, c1);
    idle_cycles(40);
    check("t5_commits", commit_q.size(), 4);
    check("t5_locks", lock_q.size(), 1);
    if (lock_q.size() > 0) check("t5_lock_at", lock_q[0] - c0, 16);
    for (int i = 0; i < 5; i++) exp_q.push_back(2'd0);
    check_ops("t5");

    // Reset while waiting for the result; the late result is ignored.
    clear_logs();
    fixed_delay = 2;
    drive_pulse(1, 0, 0, 0, 0, c0);
    found = 0;
    n = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      if (dbg_state == WAIT) found = 1;
      n++;
    end
    check("t6_reach_wait", found, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("t6_req", chk.chk_req, 0);
    check("t6_busy", busy, 0);
    check("t6_state", dbg_state, IDLE);
    rst = 0;
    idle_cycles(8);
    check("t6_commits", commit_q.size(), 0);
    check("t6_locks", lock_q.size(), 0);
    fixed_delay = 0;

    // Hard drop that never collides stops at the row cap.
    clear_logs();
    drive_pulse(0, 0, 0, 0, 1, c0);
    idle_cycles(90);
    check("t7_commits", commit_q.size(), ROWS);
    check("t7_locks", lock_q.size(), 1);
    if (lock_q.size() > 0) check("t7_lock_at", lock_q[0] - c0, 4 + 3 * (ROWS - 1) + 1);

    // Randomized traffic against the model.
    ready_rand = 1; fixed_delay = -1; col_rand = 1; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 299) == 0);
      piece_active = ($urandom_range(0, 49) != 0);
      tick         = ($urandom_range(0, 9) == 0);
      btn_left     = ($urandom_range(0, 11) == 0);
      btn_right    = ($urandom_range(0, 11) == 0);
      btn_rotate   = ($urandom_range(0, 11) == 0);
      btn_drop     = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    rst = 0; piece_active = 1;
    tick = 0; btn_left = 0; btn_right = 0; btn_rotate = 0; btn_drop = 0;
    idle_cycles(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
